// File: rtl/ooo_pkg.sv
// Shared widths and record types for the out-of-order backend.
// The reservation-station entry and the registered issue slot live here.
package ooo_pkg;

  localparam int PREG_W = 7;
  localparam int ROB_W  = 5;
  localparam int OP_W   = 6;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic              s1_rdy;
    logic              s2_rdy;
    logic [ROB_W-1:0]  rob_tag;
  } rs_entry_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [ROB_W-1:0]  rob_tag;
  } issue_slot_t;

  // True when any of the three writeback broadcasts produces preg ps.
  function automatic logic wb_match(
    input logic              aluEn,
    input logic [PREG_W-1:0] aluPd,
    input logic              bEn,
    input logic [PREG_W-1:0] bPd,
    input logic              memEn,
    input logic [PREG_W-1:0] memPd,
    input logic [PREG_W-1:0] ps
  );
    return (aluEn && (aluPd == ps)) || (bEn && (bPd == ps)) || (memEn && (memPd == ps));
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: r_age[i][j]=1 means entry i is older than entry j.
// Grants the one requesting entry that no other requester is older than.
module rs_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] i_set,
  input  logic [DEPTH-1:0] i_clr,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);

  logic [DEPTH-1:0] r_age [DEPTH];

  // A newly written entry is younger than everyone: clear its row, set its column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i_set[i])                r_age[i][j] <= 1'b0;
          else if (i_set[j] && i != j) r_age[i][j] <= 1'b1;
          else if (i_clr[i])           r_age[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && i_req[j] && r_age[j][i]) o_grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: holds uops until both sources are ready,
// wakes them from the three writeback buses, and issues the oldest ready one.
module rs_issue_queue
  import ooo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [PREG_W-1:0] disp_pd,
  input  logic [PREG_W-1:0] disp_ps1,
  input  logic [PREG_W-1:0] disp_ps2,
  input  logic              disp_ps1_rdy,
  input  logic              disp_ps2_rdy,
  input  logic [ROB_W-1:0]  disp_rob_tag,
  input  logic              wb_alu_en,
  input  logic [PREG_W-1:0] wb_alu_pd,
  input  logic              wb_b_en,
  input  logic [PREG_W-1:0] wb_b_pd,
  input  logic              wb_mem_en,
  input  logic [PREG_W-1:0] wb_mem_pd,
  output logic              issue_valid,
  output logic [PREG_W-1:0] issue_ps1,
  output logic [PREG_W-1:0] issue_ps2,
  output logic [PREG_W-1:0] issue_pd,
  output logic [OP_W-1:0]   issue_op,
  output logic [ROB_W-1:0]  issue_rob_tag,
  input  logic              fu_ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t   r_ent [DEPTH];
  issue_slot_t r_slot;

  logic [DEPTH-1:0] w_s1Hit, w_s2Hit, w_ready, w_grant, w_dispSet, w_issueClr;
  logic             w_hasFree, w_load, w_issueFire, w_dispFire;
  logic [IDX_W-1:0] w_freeIdx;
  rs_entry_t        w_newEnt;
  issue_slot_t      w_selSlot;

  // Same-cycle wakeup counts towards readiness so a broadcast can select immediately.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_s1Hit[i] = wb_match(wb_alu_en, wb_alu_pd, wb_b_en, wb_b_pd, wb_mem_en, wb_mem_pd, r_ent[i].ps1);
      w_s2Hit[i] = wb_match(wb_alu_en, wb_alu_pd, wb_b_en, wb_b_pd, wb_mem_en, wb_mem_pd, r_ent[i].ps2);
      w_ready[i] = r_ent[i].valid && (r_ent[i].s1_rdy || w_s1Hit[i]) && (r_ent[i].s2_rdy || w_s2Hit[i]);
    end
  end

  always_comb begin
    w_hasFree = 1'b0;
    w_freeIdx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_ent[i].valid) begin
        w_hasFree = 1'b1;
        w_freeIdx = IDX_W'(i);
      end
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .reset   (reset),
    .i_set   (w_dispSet),
    .i_clr   (w_issueClr),
    .i_req   (w_ready),
    .o_grant (w_grant)
  );

  assign w_load      = !r_slot.valid || fu_ready;
  assign w_issueFire = w_load && (|w_ready) && !flush;
  assign w_issueClr  = w_issueFire ? w_grant : '0;
  assign w_dispFire  = disp_valid && w_hasFree && !flush;
  assign w_dispSet   = w_dispFire ? (DEPTH'(1) << w_freeIdx) : '0;

  always_comb begin
    w_newEnt         = '0;
    w_newEnt.valid   = 1'b1;
    w_newEnt.op      = disp_op;
    w_newEnt.pd      = disp_pd;
    w_newEnt.ps1     = disp_ps1;
    w_newEnt.ps2     = disp_ps2;
    w_newEnt.rob_tag = disp_rob_tag;
    w_newEnt.s1_rdy  = disp_ps1_rdy |
                       wb_match(wb_alu_en, wb_alu_pd, wb_b_en, wb_b_pd, wb_mem_en, wb_mem_pd, disp_ps1);
    w_newEnt.s2_rdy  = disp_ps2_rdy |
                       wb_match(wb_alu_en, wb_alu_pd, wb_b_en, wb_b_pd, wb_mem_en, wb_mem_pd, disp_ps2);
  end

  always_comb begin
    w_selSlot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_selSlot.valid   = 1'b1;
        w_selSlot.op      = r_ent[i].op;
        w_selSlot.pd      = r_ent[i].pd;
        w_selSlot.ps1     = r_ent[i].ps1;
        w_selSlot.ps2     = r_ent[i].ps2;
        w_selSlot.rob_tag = r_ent[i].rob_tag;
      end
    end
  end

  // The dispatch target is free in registered state, so it never collides with the issued entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_dispSet[i]) begin
          r_ent[i] <= w_newEnt;
        end else begin
          if (w_issueClr[i]) r_ent[i].valid  <= 1'b0;
          if (w_s1Hit[i])    r_ent[i].s1_rdy <= 1'b1;
          if (w_s2Hit[i])    r_ent[i].s2_rdy <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
    end else if (flush) begin
      r_slot <= '0;
    end else if (w_load) begin
      if (|w_ready) r_slot       <= w_selSlot;
      else          r_slot.valid <= 1'b0;
    end
  end

  assign disp_ready    = w_hasFree;
  assign issue_valid   = r_slot.valid;
  assign issue_ps1     = r_slot.ps1;
  assign issue_ps2     = r_slot.ps2;
  assign issue_pd      = r_slot.pd;
  assign issue_op      = r_slot.op;
  assign issue_rob_tag = r_slot.rob_tag;

endmodule
